// File: rtl/nios_dbg_mon_pkg.sv
// Shared types and jdo field positions for the debug monitor memory-access block.
package nios_dbg_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  localparam int JDO_DATA_LSB = 3;
  localparam int JDO_DATA_MSB = 34;
  localparam int JDO_ADDR_LSB = 3;
  localparam int JDO_BE_LSB   = 34;
  localparam int JDO_BE_MSB   = 37;

endpackage

// File: rtl/nios_dbg_mon_watchdog.sv
// Per-access timeout counter: cleared while idle, counts while an access is
// outstanding, and pulses expire on the cycle the budget runs out.
module nios_dbg_mon_watchdog #(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [15:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  // Firing one count early makes the request visible for exactly TIMEOUT_CYC cycles.
  assign expire = enable && (count == 16'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/nios_dbg_mon_access.sv
// Turns debug-slave command pulses into single Avalon-MM word accesses.
// Optional macro NIOS_DBG_MON_BYTEEN_EN: address load also latches byte enables from jdo.
module nios_dbg_mon_access
  import nios_dbg_mon_pkg::*;
#(
  parameter int ADDR_W      = 26,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic [ADDR_W+1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid
);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] word_addr;
  logic              expire;
  logic              cmd_load;
  logic              cmd_write;
  logic              cmd_read;
  logic              req_accept;
  logic              done_write;
  logic              done_read;
  logic              abort;
  logic              busy_drop;

  nios_dbg_mon_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == IDLE),
    .enable (state != IDLE),
    .expire (expire)
  );

  always_comb begin
    state_next = state;
    cmd_load   = 1'b0;
    cmd_write  = 1'b0;
    cmd_read   = 1'b0;
    req_accept = 1'b0;
    done_write = 1'b0;
    done_read  = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (take_action_ocimem_a) begin
          cmd_load = 1'b1;
        end else if (take_action_ocimem_b) begin
          cmd_write  = 1'b1;
          state_next = REQ;
        end else if (take_no_action_ocimem_a) begin
          cmd_read   = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        // Acceptance wins over a simultaneous timeout.
        if (!avm_waitrequest) begin
          req_accept = 1'b1;
          if (avm_write) begin
            done_write = 1'b1;
            state_next = IDLE;
          end else if (avm_readdatavalid) begin
            done_read  = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = RDWAIT;
          end
        end else if (expire) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      RDWAIT: begin
        if (avm_readdatavalid) begin
          done_read  = 1'b1;
          state_next = IDLE;
        end else if (expire) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    busy_drop = (state != IDLE) &&
                (take_action_ocimem_a || take_action_ocimem_b || take_no_action_ocimem_a);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      word_addr     <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= '0;
    end else begin
      state <= state_next;
      if (cmd_load) begin
        word_addr     <= jdo[JDO_ADDR_LSB+ADDR_W-1:JDO_ADDR_LSB];
        monitor_error <= 1'b0;
      end
      if (cmd_write) begin
        avm_write     <= 1'b1;
        avm_writedata <= jdo[JDO_DATA_MSB:JDO_DATA_LSB];
        MonDReg       <= jdo[JDO_DATA_MSB:JDO_DATA_LSB];
        monitor_ready <= 1'b0;
        monitor_error <= 1'b0;
      end
      if (cmd_read) begin
        avm_read      <= 1'b1;
        monitor_ready <= 1'b0;
        monitor_error <= 1'b0;
      end
      if (req_accept) begin
        avm_read  <= 1'b0;
        avm_write <= 1'b0;
      end
      if (done_write || done_read) begin
        word_addr     <= word_addr + ADDR_W'(1);
        monitor_ready <= 1'b1;
      end
      if (done_read) begin
        MonDReg <= avm_readdata;
      end
      if (abort) begin
        avm_read      <= 1'b0;
        avm_write     <= 1'b0;
        monitor_ready <= 1'b1;
        monitor_error <= 1'b1;
      end
      // Error from a dropped pulse survives completion of the running access.
      if (busy_drop) begin
        monitor_error <= 1'b1;
      end
    end
  end

  assign avm_address = {word_addr, 2'b00};

`ifdef NIOS_DBG_MON_BYTEEN_EN
  logic [3:0] byteenable;

  always_ff @(posedge clk) begin
    if (reset) begin
      byteenable <= 4'hF;
    end else if (cmd_load) begin
      byteenable <= jdo[JDO_BE_MSB:JDO_BE_LSB];
    end
  end

  assign avm_byteenable = byteenable;
`else
  assign avm_byteenable = 4'hF;
`endif

endmodule

// File: tb/tb_nios_dbg_mon_access.sv
// Bench for nios_dbg_mon_access: a 26-bit-address instance plus an 8-bit-address
// instance sharing the same stimulus, with a queue of expected MonDReg results.
module tb_nios_dbg_mon_access;

  logic        clk;
  logic        reset;
  logic [37:0] jdo;
  logic        ta_a;
  logic        ta_b;
  logic        tna_a;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        avm_readdatavalid;

  logic [31:0] mon_dreg;
  logic        monitor_ready;
  logic        monitor_error;
  logic [27:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;

  logic [31:0] mon_dreg8;
  logic        monitor_ready8;
  logic        monitor_error8;
  logic [9:0]  avm_address8;
  logic        avm_read8;
  logic        avm_write8;
  logic [31:0] avm_writedata8;
  logic [3:0]  avm_byteenable8;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  logic [3:0]  exp_be;
  bit          ok;

  nios_dbg_mon_access #(.ADDR_W(26), .TIMEOUT_CYC(15)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(ta_a), .take_action_ocimem_b(ta_b),
    .take_no_action_ocimem_a(tna_a),
    .MonDReg(mon_dreg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .avm_readdatavalid(avm_readdatavalid)
  );

  nios_dbg_mon_access #(.ADDR_W(8), .TIMEOUT_CYC(15)) dut8 (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(ta_a), .take_action_ocimem_b(ta_b),
    .take_no_action_ocimem_a(tna_a),
    .MonDReg(mon_dreg8), .monitor_ready(monitor_ready8), .monitor_error(monitor_error8),
    .avm_address(avm_address8), .avm_read(avm_read8), .avm_write(avm_write8),
    .avm_writedata(avm_writedata8), .avm_byteenable(avm_byteenable8),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .avm_readdatavalid(avm_readdatavalid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] jdo_addr(input logic [25:0] a, input logic [3:0] be);
    logic [33:0] low;
    low = 34'(a) << 3;
    return {be, low};
  endfunction

  function automatic logic [37:0] jdo_data(input logic [31:0] d);
    return {3'b000, d, 3'b000};
  endfunction

  // driver tasks
  task automatic pulse(input bit a, input bit b, input bit n, input logic [37:0] j);
    jdo = j; ta_a = a; ta_b = b; tna_a = n;
    tick();
    ta_a = 1'b0; ta_b = 1'b0; tna_a = 1'b0;
  endtask

  task automatic wait_ready(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (monitor_ready) begin
        seen = 1'b1;
        return;
      end
      tick();
    end
    seen = monitor_ready;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    total++; if (mon_dreg !== 32'h0) begin bad++; $display("FAIL reset_mondreg got=%h want=0", mon_dreg); end
    total++; if (monitor_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", monitor_ready); end
    total++; if (monitor_error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", monitor_error); end
    total++; if ({avm_read, avm_write} !== 2'b00) begin bad++; $display("FAIL reset_req got=%b want=00", {avm_read, avm_write}); end
    total++; if (avm_address !== 28'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", avm_address); end
    total++; if (avm_byteenable !== 4'hF) begin bad++; $display("FAIL reset_be got=%h want=f", avm_byteenable); end
    total++; if (avm_writedata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h want=0", avm_writedata); end
  endtask

  task automatic test_read();
    pulse(1, 0, 0, jdo_addr(26'h100, 4'hF));
    total++; if (avm_address !== 28'h400) begin bad++; $display("FAIL read_load_addr got=%h want=400", avm_address); end
    avm_waitrequest = 1'b1;
    pulse(0, 0, 1, 38'h0);
    exp_q.push_back(32'hDEADBEEF);
    total++; if ({avm_read, monitor_ready} !== 2'b10) begin bad++; $display("FAIL read_issue got=%b want=10", {avm_read, monitor_ready}); end
    repeat (2) tick();
    total++; if (avm_read !== 1'b1 || avm_address !== 28'h400) begin bad++; $display("FAIL read_hold got=%b/%h want=1/400", avm_read, avm_address); end
    avm_waitrequest = 1'b0;
    tick();
    total++; if ({avm_read, monitor_ready} !== 2'b00) begin bad++; $display("FAIL read_rdwait got=%b want=00", {avm_read, monitor_ready}); end
    avm_readdatavalid = 1'b1; avm_readdata = 32'hDEADBEEF;
    tick();
    avm_readdatavalid = 1'b0; avm_readdata = 32'h0;
    wait_ready(4, ok);
    total++; if (!ok) begin bad++; $display("FAIL read_ready_timeout got=%b want=1", monitor_ready); end
    exp_v = exp_q.pop_front();
    total++; if (mon_dreg !== exp_v) begin bad++; $display("FAIL read_data got=%h want=%h", mon_dreg, exp_v); end
    total++; if (avm_address !== 28'h404) begin bad++; $display("FAIL read_incr got=%h want=404", avm_address); end
  endtask

  task automatic test_write();
    pulse(1, 0, 0, jdo_addr(26'h20, 4'hF));
    avm_waitrequest = 1'b0;
    for (int k = 0; k < 2; k++) begin
      pulse(0, 1, 0, jdo_data(32'h12345678));
      exp_q.push_back(32'h12345678);
      total++; if (avm_write !== 1'b1 || avm_address !== 28'(32'h80 + 4 * k)) begin bad++; $display("FAIL write_issue%0d got=%b/%h want=1/%h", k, avm_write, avm_address, 32'h80 + 4 * k); end
      total++; if (avm_writedata !== 32'h12345678) begin bad++; $display("FAIL write_wdata%0d got=%h want=12345678", k, avm_writedata); end
      tick();
      total++; if (monitor_ready !== 1'b1 || avm_write !== 1'b0) begin bad++; $display("FAIL write_latency%0d got=%b/%b want=1/0", k, monitor_ready, avm_write); end
      exp_v = exp_q.pop_front();
      total++; if (mon_dreg !== exp_v) begin bad++; $display("FAIL write_mondreg%0d got=%h want=%h", k, mon_dreg, exp_v); end
    end
    total++; if (avm_address !== 28'h88) begin bad++; $display("FAIL write_incr got=%h want=88", avm_address); end
  endtask

  task automatic test_wrap();
    pulse(1, 0, 0, jdo_addr(26'hFF, 4'hF));
    avm_waitrequest = 1'b0;
    pulse(0, 0, 1, 38'h0);
    exp_q.push_back(32'hA5A50001);
    total++; if (avm_read8 !== 1'b1 || avm_address8 !== 10'h3FC) begin bad++; $display("FAIL wrap_issue got=%b/%h want=1/3fc", avm_read8, avm_address8); end
    // data returns in the acceptance cycle
    avm_readdatavalid = 1'b1; avm_readdata = 32'hA5A50001;
    tick();
    avm_readdatavalid = 1'b0; avm_readdata = 32'h0;
    total++; if (monitor_ready8 !== 1'b1 || avm_address8 !== 10'h000) begin bad++; $display("FAIL wrap_addr8 got=%b/%h want=1/000", monitor_ready8, avm_address8); end
    total++; if (monitor_error8 !== 1'b0) begin bad++; $display("FAIL wrap_error got=%b want=0", monitor_error8); end
    total++; if (avm_address !== 28'h400) begin bad++; $display("FAIL wrap_addr26 got=%h want=400", avm_address); end
    exp_v = exp_q.pop_front();
    total++; if (mon_dreg8 !== exp_v) begin bad++; $display("FAIL wrap_data got=%h want=%h", mon_dreg8, exp_v); end
  endtask

  task automatic test_priority();
    pulse(1, 1, 0, jdo_addr(26'h30, 4'hF));
    total++; if (avm_write !== 1'b0 || avm_address !== 28'hC0) begin bad++; $display("FAIL prio_load got=%b/%h want=0/c0", avm_write, avm_address); end
    avm_waitrequest = 1'b0;
    pulse(0, 1, 1, jdo_data(32'h55));
    exp_q.push_back(32'h55);
    total++; if ({avm_write, avm_read} !== 2'b10) begin bad++; $display("FAIL prio_write got=%b want=10", {avm_write, avm_read}); end
    tick();
    exp_v = exp_q.pop_front();
    total++; if (mon_dreg !== exp_v || monitor_ready !== 1'b1) begin bad++; $display("FAIL prio_done got=%h/%b want=%h/1", mon_dreg, monitor_ready, exp_v); end
  endtask

  task automatic test_timeout();
    int n;
    pulse(1, 0, 0, jdo_addr(26'h40, 4'hF));
    avm_waitrequest = 1'b1;
    pulse(0, 1, 0, jdo_data(32'hCAFEF00D));
    exp_q.push_back(32'hCAFEF00D);
    n = 0;
    while (avm_write === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    avm_waitrequest = 1'b0;
    total++; if (n !== 15) begin bad++; $display("FAIL timeout_cycles got=%0d want=15", n); end
    total++; if ({monitor_ready, monitor_error} !== 2'b11) begin bad++; $display("FAIL timeout_flags got=%b want=11", {monitor_ready, monitor_error}); end
    total++; if (avm_address !== 28'h100) begin bad++; $display("FAIL timeout_addr got=%h want=100", avm_address); end
    exp_v = exp_q.pop_front();
    total++; if (mon_dreg !== exp_v) begin bad++; $display("FAIL timeout_mondreg got=%h want=%h", mon_dreg, exp_v); end
    avm_readdatavalid = 1'b1; avm_readdata = 32'hFFFF0000;
    tick();
    avm_readdatavalid = 1'b0; avm_readdata = 32'h0;
    total++; if (mon_dreg !== 32'hCAFEF00D || avm_address !== 28'h100) begin bad++; $display("FAIL late_rdv got=%h/%h want=cafef00d/100", mon_dreg, avm_address); end
    pulse(1, 0, 0, jdo_addr(26'h40, 4'hF));
    total++; if (monitor_error !== 1'b0) begin bad++; $display("FAIL timeout_clear got=%b want=0", monitor_error); end
  endtask

  task automatic test_busy_drop();
    pulse(1, 0, 0, jdo_addr(26'h10, 4'hF));
    avm_waitrequest = 1'b0;
    pulse(0, 0, 1, 38'h0);
    exp_q.push_back(32'h0BADCAFE);
    tick();
    pulse(0, 0, 1, 38'h0);
    total++; if ({avm_read, monitor_ready} !== 2'b00) begin bad++; $display("FAIL busy_no_reissue got=%b want=00", {avm_read, monitor_ready}); end
    avm_readdatavalid = 1'b1; avm_readdata = 32'h0BADCAFE;
    tick();
    avm_readdatavalid = 1'b0; avm_readdata = 32'h0;
    total++; if ({monitor_ready, monitor_error} !== 2'b11) begin bad++; $display("FAIL busy_error got=%b want=11", {monitor_ready, monitor_error}); end
    exp_v = exp_q.pop_front();
    total++; if (mon_dreg !== exp_v || avm_address !== 28'h44) begin bad++; $display("FAIL busy_data got=%h/%h want=%h/44", mon_dreg, avm_address, exp_v); end
    pulse(0, 0, 1, 38'h0);
    exp_q.push_back(32'h00000001);
    total++; if (monitor_error !== 1'b0) begin bad++; $display("FAIL busy_clear got=%b want=0", monitor_error); end
    avm_readdatavalid = 1'b1; avm_readdata = 32'h00000001;
    tick();
    avm_readdatavalid = 1'b0; avm_readdata = 32'h0;
    wait_ready(4, ok);
    exp_v = exp_q.pop_front();
    total++; if (!ok || mon_dreg !== exp_v || avm_address !== 28'h48) begin bad++; $display("FAIL busy_next got=%b/%h/%h want=1/%h/48", ok, mon_dreg, avm_address, exp_v); end
  endtask

  task automatic test_byteen();
`ifdef NIOS_DBG_MON_BYTEEN_EN
    exp_be = 4'h3;
`else
    exp_be = 4'hF;
`endif
    pulse(1, 0, 0, jdo_addr(26'h8, 4'b0011));
    avm_waitrequest = 1'b0;
    pulse(0, 1, 0, jdo_data(32'h77));
    exp_q.push_back(32'h77);
    total++; if (avm_write !== 1'b1 || avm_byteenable !== exp_be) begin bad++; $display("FAIL byteen got=%b/%h want=1/%h", avm_write, avm_byteenable, exp_be); end
    tick();
    exp_v = exp_q.pop_front();
    total++; if (mon_dreg !== exp_v || monitor_ready !== 1'b1) begin bad++; $display("FAIL byteen_done got=%h/%b want=%h/1", mon_dreg, monitor_ready, exp_v); end
  endtask

  task automatic test_reset_mid();
    avm_waitrequest = 1'b1;
    pulse(0, 1, 0, jdo_data(32'h99));
    total++; if (avm_write !== 1'b1) begin bad++; $display("FAIL rmid_issue got=%b want=1", avm_write); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    avm_waitrequest = 1'b0;
    total++; if ({avm_read, avm_write, monitor_ready, monitor_error} !== 4'b0010) begin bad++; $display("FAIL rmid_flags got=%b want=0010", {avm_read, avm_write, monitor_ready, monitor_error}); end
    total++; if (mon_dreg !== 32'h0 || avm_address !== 28'h0 || avm_byteenable !== 4'hF) begin bad++; $display("FAIL rmid_regs got=%h/%h/%h want=0/0/f", mon_dreg, avm_address, avm_byteenable); end
    tick();
  endtask

  initial begin
    reset = 1'b1; jdo = '0; ta_a = 1'b0; ta_b = 1'b0; tna_a = 1'b0;
    avm_readdata = '0; avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_wrap();
    test_priority();
    test_timeout();
    test_busy_drop();
    test_byteen();
    test_reset_mid();
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL queue_left got=%0d want=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=stalled want=finished");
    $fatal(1, "bench stalled");
  end

endmodule
